hw_stack: RTL and testbench

Parametrised hardware stack for the CPU, the successor to the fixed 32×1024 stack. Stores one register-wide word per entry, with configurable width and depth, explicit full/empty status, an occupancy count, defined simultaneous push+pop (replace-top) semantics, and optional sticky overflow/underflow detection. Sits beside the register file and is driven by the CPU control unit's push/pop decode.

---
 rtl/hw_stack_pkg.sv | 15 +
 rtl/hw_stack_ram.sv | 26 ++
 rtl/hw_stack.sv | 112 +++++++++++
 tb/tb_hw_stack.sv | 129 ++++++++++++
 4 files changed

// File: rtl/hw_stack_pkg.sv
// Shared constants and helpers for the CPU hardware stack.
package hw_stack_pkg;

  localparam int unsigned HW_STACK_DATA_W = 32;
  localparam int unsigned HW_STACK_DEPTH  = 1024;

  // Ceiling log2, usable in parameter defaults.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/hw_stack_ram.sv
// DEPTH x DATA_W synchronous RAM: one write port, one registered read-first read port.
module stack_ram
  import hw_stack_pkg::*;
#(
  parameter int unsigned DATA_W = HW_STACK_DATA_W,
  parameter int unsigned DEPTH  = HW_STACK_DEPTH,
  parameter int unsigned ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read returns the pre-write word when both ports hit the same address.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/hw_stack.sv
// Parametrised CPU stack: pointer, control and flag logic around stack_ram.
// Optional sticky ovf/udf flags are enabled with `define HW_STACK_ERR_EN.
module hw_stack
  import hw_stack_pkg::*;
#(
  parameter int unsigned DATA_W = HW_STACK_DATA_W,
  parameter int unsigned DEPTH  = HW_STACK_DEPTH,
  parameter int unsigned ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] d,
  input  logic              push,
  input  logic              pop,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  input  logic              err_clr,
  output logic              ovf,
  output logic              udf
);

  logic [ADDR_W:0]   ptr, ptr_nxt;
  logic [ADDR_W-1:0] top_addr;
  logic              do_push, do_pop, replace, pass, rej_push, rej_pop;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_rdata, byp;
  logic              q_sel;

  assign top_addr = ADDR_W'(ptr - (ADDR_W+1)'(1));

  always_comb begin
    do_push  = push & ~pop & ~full;
    do_pop   = pop & ~push & ~empty;
    replace  = push & pop & ~empty;
    pass     = push & pop & empty;
    rej_push = push & ~pop & full;
    rej_pop  = pop & ~push & empty;
  end

  // Push writes the free slot; replace-top overwrites the current top.
  always_comb begin
    ram_we    = do_push | replace;
    ram_waddr = replace ? top_addr : ADDR_W'(ptr);
    ptr_nxt   = ptr;
    if (do_push)     ptr_nxt = ptr + (ADDR_W+1)'(1);
    else if (do_pop) ptr_nxt = ptr - (ADDR_W+1)'(1);
  end

  stack_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (d),
    .re    (do_pop | replace),
    .raddr (top_addr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr     <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
      q_valid <= 1'b0;
      q_sel   <= 1'b0;
      byp     <= '0;
    end else begin
      ptr     <= ptr_nxt;
      empty   <= (ptr_nxt == '0);
      full    <= (ptr_nxt == (ADDR_W+1)'(DEPTH));
      q_valid <= do_pop | replace | pass;
      if (do_pop | replace) begin
        q_sel <= 1'b1;
      end else if (pass) begin
        q_sel <= 1'b0;
        byp   <= d;
      end
    end
  end

  // q selects between the RAM read register and the pass-through register.
  assign q     = q_sel ? ram_rdata : byp;
  assign count = ptr;

`ifdef HW_STACK_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (rej_push)     ovf <= 1'b1;
      else if (err_clr) ovf <= 1'b0;
      if (rej_pop)      udf <= 1'b1;
      else if (err_clr) udf <= 1'b0;
    end
  end
`else
  logic unused_err;
  assign unused_err = err_clr | rej_push | rej_pop;
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

endmodule

// File: tb/tb_hw_stack.sv
// Directed self-checking bench for hw_stack at DEPTH=4, DATA_W=32.
module tb_hw_stack;

`ifdef HW_STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, push, pop, err_clr;
  logic [31:0] d, q;
  logic        q_valid, empty, full, ovf, udf;
  logic [2:0]  count;
  int          checks = 0;
  int          errors = 0;

  hw_stack #(.DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .d(d), .push(push), .pop(pop),
    .q(q), .q_valid(q_valid), .count(count), .empty(empty), .full(full),
    .err_clr(err_clr), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, take the edge, then idle inputs and settle.
  task automatic cyc(input logic rs, input logic pu, input logic po,
                     input logic [31:0] dd, input logic ec);
    reset = rs; push = pu; pop = po; d = dd; err_clr = ec;
    @(posedge clk); #1;
    reset = 1'b0; push = 1'b0; pop = 1'b0; d = '0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 0);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_empty_full got %b%b exp 10", empty, full); end
    checks++; if (q !== 32'h0 || q_valid !== 1'b0) begin errors++; $display("FAIL reset_q got %h/%b exp 0/0", q, q_valid); end
    checks++; if (ovf !== 1'b0 || udf !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", ovf, udf); end
  endtask

  task automatic test_lifo();
    logic [31:0] exp_q [3];
    exp_q[0] = 32'h33; exp_q[1] = 32'h22; exp_q[2] = 32'h11;
    cyc(0, 1, 0, 32'h11, 0);
    cyc(0, 1, 0, 32'h22, 0);
    cyc(0, 1, 0, 32'h33, 0);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL lifo_count got %0d exp 3", count); end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0, 0);
      checks++; if (q !== exp_q[i] || q_valid !== 1'b1) begin errors++; $display("FAIL lifo_pop%0d got %h/%b exp %h/1", i, q, q_valid, exp_q[i]); end
    end
    checks++; if (empty !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL lifo_empty got %b/%0d exp 1/0", empty, count); end
  endtask

  task automatic test_full();
    for (int i = 1; i <= 4; i++) cyc(0, 1, 0, 32'h40 + 32'(i), 0);
    checks++; if (full !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL full_set got %b/%0d exp 1/4", full, count); end
    cyc(0, 1, 0, 32'h55, 0);
    checks++; if (count !== 3'd4 || q_valid !== 1'b0) begin errors++; $display("FAIL full_reject got %0d/%b exp 4/0", count, q_valid); end
    checks++; if (ovf !== ERR_EN) begin errors++; $display("FAIL full_ovf got %b exp %b", ovf, ERR_EN); end
    cyc(0, 0, 1, 0, 0);
    checks++; if (q !== 32'h44 || full !== 1'b0 || count !== 3'd3) begin errors++; $display("FAIL full_pop got %h/%b/%0d exp 44/0/3", q, full, count); end
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
    checks++; if (q !== 32'h41 || empty !== 1'b1) begin errors++; $display("FAIL full_drain got %h/%b exp 41/1", q, empty); end
    cyc(0, 0, 0, 0, 1);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL full_ovf_clr got %b exp 0", ovf); end
  endtask

  task automatic test_underflow();
    cyc(0, 0, 1, 0, 0);
    checks++; if (q !== 32'h41 || q_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL udf_pop got %h/%b/%0d exp 41/0/0", q, q_valid, count); end
    checks++; if (udf !== ERR_EN || ovf !== 1'b0) begin errors++; $display("FAIL udf_set got %b/%b exp %b/0", udf, ovf, ERR_EN); end
    cyc(0, 0, 0, 0, 1);
    checks++; if (udf !== 1'b0) begin errors++; $display("FAIL udf_clr got %b exp 0", udf); end
    cyc(0, 0, 1, 0, 1);
    checks++; if (udf !== ERR_EN) begin errors++; $display("FAIL udf_set_prio got %b exp %b", udf, ERR_EN); end
    cyc(0, 0, 0, 0, 1);
  endtask

  task automatic test_replace();
    cyc(0, 1, 0, 32'hA, 0);
    cyc(0, 1, 1, 32'hB, 0);
    checks++; if (q !== 32'hA || q_valid !== 1'b1 || count !== 3'd1) begin errors++; $display("FAIL replace_top got %h/%b/%0d exp a/1/1", q, q_valid, count); end
    cyc(0, 0, 1, 0, 0);
    checks++; if (q !== 32'hB || count !== 3'd0) begin errors++; $display("FAIL replace_pop got %h/%0d exp b/0", q, count); end
  endtask

  task automatic test_pass_through();
    cyc(0, 1, 1, 32'hC, 0);
    checks++; if (q !== 32'hC || q_valid !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL pass_q got %h/%b/%0d exp c/1/0", q, q_valid, count); end
    checks++; if (ovf !== 1'b0 || udf !== 1'b0) begin errors++; $display("FAIL pass_flags got %b%b exp 00", ovf, udf); end
    for (int i = 1; i <= 4; i++) cyc(0, 1, 0, 32'(i), 0);
    cyc(0, 1, 1, 32'h9, 0);
    checks++; if (count !== 3'd4 || ovf !== 1'b0 || q !== 32'h4) begin errors++; $display("FAIL full_replace got %0d/%b/%h exp 4/0/4", count, ovf, q); end
    cyc(0, 0, 1, 0, 0);
    checks++; if (q !== 32'h9 || q_valid !== 1'b1) begin errors++; $display("FAIL full_replace_pop got %h/%b exp 9/1", q, q_valid); end
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
    checks++; if (q !== 32'h1 || empty !== 1'b1) begin errors++; $display("FAIL pass_drain got %h/%b exp 1/1", q, empty); end
  endtask

  task automatic test_reset_priority();
    cyc(0, 1, 0, 32'h71, 0);
    cyc(0, 1, 0, 32'h72, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 32'h73, 0);
    checks++; if (count !== 3'd2 || q !== 32'h72) begin errors++; $display("FAIL pre_reset got %0d/%h exp 2/72", count, q); end
    cyc(1, 1, 0, 32'h74, 0);
    checks++; if (count !== 3'd0 || q !== 32'h0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_push got %0d/%h/%b%b exp 0/0/10", count, q, empty, full); end
    checks++; if (ovf !== 1'b0 || udf !== 1'b0 || q_valid !== 1'b0) begin errors++; $display("FAIL reset_push_flags got %b%b%b exp 000", ovf, udf, q_valid); end
    cyc(0, 0, 1, 0, 0);
    checks++; if (udf !== ERR_EN || q_valid !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL reset_then_pop got %b/%b/%b exp %b/0/0", udf, q_valid, ovf, ERR_EN); end
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; d = '0; err_clr = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_lifo();
    test_full();
    test_underflow();
    test_replace();
    test_pass_through();
    test_reset_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
